// File: rtl/router_pkg.sv
// router_pkg: shared packet layout, address map and state definitions for the router scheduler
package router_pkg;
  localparam int NREQ = 4;
  localparam int PKT_W = 43;
  localparam int CNT_HI = 42;
  localparam int CNT_LO = 40;
  localparam int ADDR_HI = 39;
  localparam int ADDR_LO = 24;
  localparam int PAY_HI = 23;
  localparam int PAY_LO = 0;
  localparam logic [15:0] ADDR_A = 16'h53A8;
  localparam logic [15:0] ADDR_B = 16'hAA99;
  localparam logic [15:0] ADDR_C = 16'h6894;
  localparam logic [15:0] ADDR_D = 16'hBC27;
  typedef enum logic [1:0] {CH_A, CH_B, CH_C, CH_D} chan_e;
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DROP} state_e;
  typedef struct packed {
    logic known;
    chan_e ch;
  } dec_t;
  function automatic dec_t decode_addr(input logic [15:0] a);
    dec_t d;
    d.known = 1'b1;
    d.ch = CH_A;
    case (a)
      ADDR_A: d.ch = CH_A;
      ADDR_B: d.ch = CH_B;
      ADDR_C: d.ch = CH_C;
      ADDR_D: d.ch = CH_D;
      default: d.known = 1'b0;
    endcase
    return d;
  endfunction
endpackage

// File: rtl/router_scheduler_if.sv
// router_scheduler_if: ingress request bus and egress channel bus of the router scheduler
interface router_scheduler_if;
  import router_pkg::*;
  logic [NREQ-1:0] req_valid;
  logic [NREQ*PKT_W-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic [PKT_W-1:0] out_data;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic busy;
  logic drop_pulse;
  logic [7:0] drop_cnt;
  logic [1:0] last_grant;
  modport slave (
    input req_valid, req_data, out_ready,
    output req_ready, out_data, out_valid, busy, drop_pulse, drop_cnt, last_grant
  );
  modport master (
    output req_valid, req_data, out_ready,
    input req_ready, out_data, out_valid, busy, drop_pulse, drop_cnt, last_grant
  );
endinterface

// File: rtl/router_scheduler_rr_arbiter4.sv
// rr_arbiter4: combinational 4-way round-robin arbiter, searching upward from i_ptr+1 with wrap
module rr_arbiter4 (
  input  logic [3:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [3:0] o_grant,
  output logic [1:0] o_idx
);
  logic [1:0] w_j;
  always_comb begin
    o_grant = 4'b0000;
    o_idx = 2'd0;
    w_j = 2'd0;
    // walk from the farthest candidate back so the nearest valid one wins
    for (int k = 3; k >= 0; k--) begin
      w_j = i_ptr + 2'd1 + 2'(k);
      if (i_req[w_j]) begin
        o_grant = 4'b0001 << w_j;
        o_idx = w_j;
      end
    end
  end
endmodule

// File: rtl/router_scheduler.sv
// router_scheduler: grants one ingress packet at a time, replays it count times on its decoded
// channel under backpressure, and drops zero-count or unknown-address packets.
module router_scheduler (
  input  logic clk,
  input  logic rst,
  router_scheduler_if.slave bus
);
  import router_pkg::*;
  state_e r_state, w_state_nx;
  logic [PKT_W-1:0] r_pkt, w_pkt_nx, w_sel, r_out_data;
  logic [2:0] r_rem;
  chan_e r_ch, w_ch_nx;
  logic [1:0] r_last, w_idx;
  logic [7:0] r_drop_cnt;
  logic [3:0] r_out_valid, w_grant;
  logic r_busy, r_drop_pulse, w_xfer, w_fire;
  dec_t w_dec;
  rr_arbiter4 u_arb (
    .i_req(bus.req_valid),
    .i_ptr(r_last),
    .o_grant(w_grant),
    .o_idx(w_idx)
  );
  assign bus.req_ready = (rst && r_state == S_IDLE) ? w_grant : 4'b0000;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data = r_out_data;
  assign bus.busy = r_busy;
  assign bus.drop_pulse = r_drop_pulse;
  assign bus.drop_cnt = r_drop_cnt;
  assign bus.last_grant = r_last;
  always_comb begin
    w_sel = bus.req_data[w_idx*PKT_W +: PKT_W];
    w_dec = decode_addr(w_sel[ADDR_HI:ADDR_LO]);
    w_xfer = |bus.req_ready;
    w_fire = r_state == S_SEND && bus.out_ready[r_ch];
    w_ch_nx = w_xfer ? w_dec.ch : r_ch;
    w_pkt_nx = w_xfer ? w_sel : r_pkt;
    w_state_nx = r_state == S_IDLE ? (w_xfer ? ((w_sel[CNT_HI:CNT_LO] == 3'd0 || !w_dec.known) ? S_DROP : S_SEND) : S_IDLE)
               : r_state == S_SEND ? ((w_fire && r_rem == 3'd1) ? S_IDLE : S_SEND)
               : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_pkt <= '0;
      r_rem <= 3'd0;
      r_ch <= CH_A;
      r_last <= 2'd3;
      r_drop_cnt <= 8'd0;
      r_out_valid <= 4'b0000;
      r_out_data <= '0;
      r_busy <= 1'b0;
      r_drop_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_pkt <= w_pkt_nx;
      r_ch <= w_ch_nx;
      if (w_xfer) begin
        r_rem <= w_sel[CNT_HI:CNT_LO];
        r_last <= w_idx;
      end else if (w_fire) begin
        r_rem <= r_rem - 3'd1;
      end
      if (w_state_nx == S_DROP && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
      r_drop_pulse <= w_state_nx == S_DROP;
      r_busy <= w_state_nx != S_IDLE;
      r_out_valid <= w_state_nx == S_SEND ? 4'b0001 << w_ch_nx : 4'b0000;
      r_out_data <= w_state_nx == S_SEND ? w_pkt_nx : '0;
    end
  end
endmodule

// File: tb/tb_router_scheduler.sv
// tb_router_scheduler: directed checks of grant order, replay, drops, backpressure and reset
module tb_router_scheduler;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_err = 0;
  router_scheduler_if bus ();
  router_scheduler u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [42:0] pkt(input logic [2:0] c, input logic [15:0] a, input logic [23:0] p);
    return {c, a, p};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic set_req(input int i, input logic [42:0] p);
    bus.req_data[i*43 +: 43] = p;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b0;
    bus.req_valid = 4'b0000;
    bus.req_data = '0;
    bus.out_ready = 4'b1111;
    step();
    step();
    bus.req_valid = 4'b1111;
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_out_data", 64'(bus.out_data), 64'h0);
    chk("rst_drop_pulse", 64'(bus.drop_pulse), 64'h0);
    chk("rst_drop_cnt", 64'(bus.drop_cnt), 64'h0);
    chk("rst_last_grant", 64'(bus.last_grant), 64'h3);
    bus.req_valid = 4'b0000;
    // single packet: 3 copies to channel A
    step();
    rst = 1'b1;
    set_req(0, pkt(3'd3, 16'h53A8, 24'h0ABCDE));
    bus.req_valid = 4'b0001;
    #1;
    chk("single_req_ready", 64'(bus.req_ready), 64'h1);
    step();
    bus.req_valid = 4'b0000;
    for (int c = 1; c <= 3; c++) begin
      #1;
      chk($sformatf("single_valid_c%0d", c), 64'(bus.out_valid), 64'h1);
      chk($sformatf("single_data_c%0d", c), 64'(bus.out_data), 64'(pkt(3'd3, 16'h53A8, 24'h0ABCDE)));
      chk($sformatf("single_busy_c%0d", c), 64'(bus.busy), 64'h1);
      chk($sformatf("single_req_ready_c%0d", c), 64'(bus.req_ready), 64'h0);
      step();
    end
    #1;
    chk("single_end_valid", 64'(bus.out_valid), 64'h0);
    chk("single_end_busy", 64'(bus.busy), 64'h0);
    chk("single_end_data", 64'(bus.out_data), 64'h0);
    chk("single_last_grant", 64'(bus.last_grant), 64'h0);
    // round robin after a fresh reset
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, pkt(3'd1, 16'hAA99, 24'(i + 16'h100)));
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("rr_ready_%0d", k), 64'(bus.req_ready), 64'(4'b0001 << (k % 4)));
      step();
      chk($sformatf("rr_valid_%0d", k), 64'(bus.out_valid), 64'h2);
      chk($sformatf("rr_data_%0d", k), 64'(bus.out_data), 64'(pkt(3'd1, 16'hAA99, 24'((k % 4) + 16'h100))));
      chk($sformatf("rr_grant_%0d", k), 64'(bus.last_grant), 64'(k % 4));
      step();
    end
    bus.req_valid = 4'b0000;
    step();
    // drops: zero count, then unknown address
    set_req(2, pkt(3'd0, 16'h53A8, 24'h1));
    bus.req_valid = 4'b0100;
    step();
    bus.req_valid = 4'b0000;
    #1;
    chk("drop0_pulse", 64'(bus.drop_pulse), 64'h1);
    chk("drop0_valid", 64'(bus.out_valid), 64'h0);
    step();
    #1;
    chk("drop0_pulse_end", 64'(bus.drop_pulse), 64'h0);
    chk("drop0_busy_end", 64'(bus.busy), 64'h0);
    set_req(2, pkt(3'd2, 16'h1234, 24'h5));
    bus.req_valid = 4'b0100;
    step();
    bus.req_valid = 4'b0000;
    #1;
    chk("drop1_pulse", 64'(bus.drop_pulse), 64'h1);
    chk("drop1_valid", 64'(bus.out_valid), 64'h0);
    chk("drop1_data", 64'(bus.out_data), 64'h0);
    step();
    #1;
    chk("drop_cnt_2", 64'(bus.drop_cnt), 64'h2);
    set_req(2, pkt(3'd0, 16'h53A8, 24'h7));
    bus.req_valid = 4'b0100;
    for (int k = 0; k < 600; k++) step();
    bus.req_valid = 4'b0000;
    step();
    step();
    #1;
    chk("drop_cnt_sat", 64'(bus.drop_cnt), 64'hFF);
    // backpressure on channel D, other channels ready
    set_req(3, pkt(3'd2, 16'hBC27, 24'h111111));
    bus.out_ready = 4'b0111;
    bus.req_valid = 4'b1000;
    #1;
    chk("bp_req_ready", 64'(bus.req_ready), 64'h8);
    step();
    bus.req_valid = 4'b0000;
    for (int c = 1; c <= 5; c++) begin
      if (c == 4) bus.out_ready = 4'b1111;
      #1;
      chk($sformatf("bp_valid_c%0d", c), 64'(bus.out_valid), 64'h8);
      chk($sformatf("bp_data_c%0d", c), 64'(bus.out_data), 64'(pkt(3'd2, 16'hBC27, 24'h111111)));
      step();
    end
    #1;
    chk("bp_end_valid", 64'(bus.out_valid), 64'h0);
    chk("bp_end_busy", 64'(bus.busy), 64'h0);
    // reset in the middle of a 7-copy replay to channel C
    set_req(1, pkt(3'd7, 16'h6894, 24'h222222));
    bus.req_valid = 4'b0010;
    step();
    bus.req_valid = 4'b0000;
    #1;
    chk("mid_valid", 64'(bus.out_valid), 64'h4);
    step();
    step();
    #1;
    chk("mid_still_valid", 64'(bus.out_valid), 64'h4);
    rst = 1'b0;
    step();
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'h0);
    chk("mid_rst_busy", 64'(bus.busy), 64'h0);
    chk("mid_rst_drop_cnt", 64'(bus.drop_cnt), 64'h0);
    chk("mid_rst_data", 64'(bus.out_data), 64'h0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, pkt(3'd1, 16'h53A8, 24'(i + 16'h300)));
    bus.req_valid = 4'b1111;
    #1;
    chk("post_rst_ready", 64'(bus.req_ready), 64'h1);
    step();
    bus.req_valid = 4'b0000;
    #1;
    chk("post_rst_grant", 64'(bus.last_grant), 64'h0);
    chk("post_rst_valid", 64'(bus.out_valid), 64'h1);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
